// File: rtl/aec_pkg.sv
// rtl/aec_pkg.sv - shared token codes, ASCII constants and FSM states for the expression transmitter
package aec_pkg;

  localparam logic [4:0] TOK_LPAREN = 5'd16;
  localparam logic [4:0] TOK_RPAREN = 5'd17;
  localparam logic [4:0] TOK_MUL    = 5'd18;
  localparam logic [4:0] TOK_ADD    = 5'd19;
  localparam logic [4:0] TOK_SUB    = 5'd20;

  localparam logic [7:0] ASC_NUL    = 8'h00;
  localparam logic [7:0] ASC_EQ     = 8'h3D;
  localparam logic [7:0] ASC_0      = 8'h30;
  localparam logic [7:0] ASC_a      = 8'h61;
  localparam logic [7:0] ASC_LPAREN = 8'h28;
  localparam logic [7:0] ASC_RPAREN = 8'h29;
  localparam logic [7:0] ASC_MUL    = 8'h2A;
  localparam logic [7:0] ASC_ADD    = 8'h2B;
  localparam logic [7:0] ASC_SUB    = 8'h2D;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    SEND_EQ,
    WAIT_RES,
    GAP
  } state_t;

endpackage

// File: rtl/aec_expr_tx_if.sv
// rtl/aec_expr_tx_if.sv - host load, character stream and result signals of the expression transmitter
interface aec_expr_tx_if #(
  parameter int MAX_TOK = 15
) ();
  logic                   load_valid;
  logic                   load_ready;
  logic [4:0]             expr_len;
  logic [MAX_TOK*5-1:0]   expr_tok;
  logic [7:0]             ascii_out;
  logic                   ready;
  logic                   res_valid;
  logic [6:0]             res_in;
  logic                   done;
  logic [6:0]             result_out;
  logic                   timeout_err;
  logic                   fmt_err;
  logic                   busy;

  // master is the host/calculator side, slave is the transmitter
  modport master (
    output load_valid, expr_len, expr_tok, res_valid, res_in,
    input  load_ready, ascii_out, ready, done, result_out, timeout_err, fmt_err, busy
  );

  modport slave (
    input  load_valid, expr_len, expr_tok, res_valid, res_in,
    output load_ready, ascii_out, ready, done, result_out, timeout_err, fmt_err, busy
  );
endinterface

// File: rtl/aec_tok2ascii.sv
// rtl/aec_tok2ascii.sv - maps a 5-bit expression token to its ASCII character and flags invalid codes
module aec_tok2ascii
  import aec_pkg::*;
(
  input  logic [4:0] tok,
  output logic [7:0] ascii,
  output logic       tok_valid
);

  always_comb begin
    ascii     = ASC_NUL;
    tok_valid = 1'b1;
    if (tok < 5'd10) begin
      ascii = ASC_0 + {3'b000, tok};
    end else if (tok < 5'd16) begin
      ascii = ASC_a + {3'b000, tok - 5'd10};
    end else begin
      case (tok)
        TOK_LPAREN: ascii = ASC_LPAREN;
        TOK_RPAREN: ascii = ASC_RPAREN;
        TOK_MUL:    ascii = ASC_MUL;
        TOK_ADD:    ascii = ASC_ADD;
        TOK_SUB:    ascii = ASC_SUB;
        default:    tok_valid = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/aec_expr_tx.sv
// rtl/aec_expr_tx.sv - serialises a token expression as ASCII terminated by '=', then waits for the result
module aec_expr_tx
  import aec_pkg::*;
#(
  parameter int MAX_TOK = 15,
  parameter int TIMEOUT = 255,
  parameter int GAP_CYC = 2
) (
  input  logic         clk,
  input  logic         rst,
  aec_expr_tx_if.slave bus
);

  localparam int NSLOT = 16;
  localparam int CW    = $clog2(TIMEOUT + 1);
  localparam int GW    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  state_t                     state, state_d;
  logic [3:0]                 idx, idx_d, len_q;
  logic [CW-1:0]              cnt, cnt_d;
  logic [GW-1:0]              gcnt, gcnt_d;
  logic [7:0]                 ascii_q, ascii_d;
  logic                       ready_q, ready_d;
  logic                       done_q, done_d;
  logic                       tmo_q, tmo_d;
  logic                       fmt_q, fmt_d;
  logic [6:0]                 result_q, result_d;
  logic                       accept;
  logic [NSLOT-1:0][7:0]      chk_asc;
  logic [NSLOT-1:0][7:0]      chr_q;
  logic [NSLOT-1:0]           tok_ok;
  logic                       len_ok;
  logic                       load_ok;
  logic [3:0]                 idx_p1;

  // Tokens are converted once at load time; the same mapping gives the validity check and the stored characters.
  for (genvar k = 0; k < NSLOT; k++) begin : g_slot
    if (k < MAX_TOK) begin : g_tok
      logic vld;
      aec_tok2ascii u_map (
        .tok       (bus.expr_tok[5*k +: 5]),
        .ascii     (chk_asc[k]),
        .tok_valid (vld)
      );
      assign tok_ok[k] = vld || (5'(k) >= bus.expr_len);
    end else begin : g_pad
      assign chk_asc[k] = ASC_NUL;
      assign tok_ok[k]  = 1'b1;
    end
  end

  assign len_ok  = (bus.expr_len != 5'd0) && (bus.expr_len <= 5'(MAX_TOK));
  assign load_ok = len_ok && (&tok_ok);
  assign idx_p1  = idx + 4'd1;

  always_comb begin
    state_d  = state;
    idx_d    = idx;
    cnt_d    = cnt;
    gcnt_d   = gcnt;
    ascii_d  = ASC_NUL;
    ready_d  = 1'b0;
    done_d   = 1'b0;
    tmo_d    = 1'b0;
    fmt_d    = 1'b0;
    result_d = result_q;
    accept   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.load_valid) begin
          if (load_ok) begin
            accept  = 1'b1;
            idx_d   = 4'd0;
            ascii_d = chk_asc[0];
            ready_d = 1'b1;
            state_d = SEND;
          end else begin
            fmt_d = 1'b1;
          end
        end
      end
      SEND: begin
        ready_d = 1'b1;
        if (idx == len_q - 4'd1) begin
          ascii_d = ASC_EQ;
          state_d = SEND_EQ;
        end else begin
          idx_d   = idx_p1;
          ascii_d = chr_q[idx_p1];
        end
      end
      SEND_EQ: begin
        cnt_d   = '0;
        state_d = WAIT_RES;
      end
      WAIT_RES: begin
        cnt_d = cnt + CW'(1);
        // A result on the final counted cycle still beats the timeout.
        if (bus.res_valid) begin
          result_d = bus.res_in;
          done_d   = 1'b1;
          gcnt_d   = '0;
          state_d  = GAP;
        end else if (cnt_d == CW'(TIMEOUT - 1)) begin
          tmo_d   = 1'b1;
          gcnt_d  = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (gcnt == GW'(GAP_CYC - 1)) begin
          state_d = IDLE;
        end else begin
          gcnt_d = gcnt + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      cnt      <= '0;
      gcnt     <= '0;
      ascii_q  <= ASC_NUL;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
      tmo_q    <= 1'b0;
      fmt_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state    <= state_d;
      idx      <= idx_d;
      cnt      <= cnt_d;
      gcnt     <= gcnt_d;
      ascii_q  <= ascii_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      tmo_q    <= tmo_d;
      fmt_q    <= fmt_d;
      result_q <= result_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chr_q <= '0;
      len_q <= '0;
    end else if (accept) begin
      chr_q <= chk_asc;
      len_q <= bus.expr_len[3:0];
    end
  end

  assign bus.ascii_out   = ascii_q;
  assign bus.ready       = ready_q;
  assign bus.done        = done_q;
  assign bus.timeout_err = tmo_q;
  assign bus.fmt_err     = fmt_q;
  assign bus.result_out  = result_q;
  assign bus.load_ready  = (state == IDLE);
  assign bus.busy        = (state != IDLE);

endmodule

// File: doc/aec_expr_tx.md
Name: aec_expr_tx

Overview:
Transmitter end of the calculator's ASCII expression interface. It accepts a packed token expression over a valid/ready load handshake and serialises it as ASCII characters, one per cycle, terminated by '=' (0x3D). It then waits for the calculator's valid/result response and reports it. It also enforces a response timeout and a mandatory inter-expression gap. It sits between the test/host control logic and the expression calculator.

Parameters:
MAX_TOK, 15, maximum tokens per expression; '=' is added on top, so at most 16 characters are sent.
TIMEOUT, 255, maximum cycles to wait for res_valid after '=' is sent.
GAP_CYC, 2, idle cycles after done or timeout before the next load is accepted; must be at least 1.

Ports:
clk  in  1  clock.
rst  in  1  reset, asynchronous, active-high.
load_valid  in  1  host offers an expression.
load_ready  out  1  block can accept an expression; high only in IDLE.
expr_len  in  5  number of tokens, 1..MAX_TOK.
expr_tok  in  MAX_TOK*5  packed tokens; token k is at bits [5k+4:5k] and is sent first for k=0.
ascii_out  out  8  character to the calculator; 0x00 whenever ready is low.
ready  out  1  ascii_out carries a valid character this cycle.
res_valid  in  1  calculator result strobe.
res_in  in  7  calculator result.
done  out  1  1-cycle pulse: result captured.
result_out  out  7  last captured result; holds until the next done.
timeout_err  out  1  1-cycle pulse: no res_valid within TIMEOUT cycles.
fmt_err  out  1  1-cycle pulse: load rejected.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: state IDLE; ascii_out=0x00; ready=0; done=0; result_out=0; timeout_err=0; fmt_err=0; busy=0; all counters 0.
- Token codes and their ASCII output:
  - 0-9 map to 0x30+code.
  - 10-15 map to 'a'-'f' (0x61+code-10).
  - 16 '(' 0x28, 17 ')' 0x29, 18 '*' 0x2A, 19 '+' 0x2B, 20 '-' 0x2D.
  - 21-31 are invalid.
- All outputs are registered.
- State IDLE:
  - load_ready=1.
  - On load_valid, check the load:
    - If expr_len==0, expr_len>MAX_TOK, or any token with index < expr_len is invalid: fmt_err pulses the next cycle and the state stays IDLE.
    - Otherwise latch expr_tok and expr_len, clear the token index, and go to SEND.
- State SEND:
  - The first character appears on the cycle after the accepting edge, with ready=1.
  - Each cycle drives ascii(token[idx]) and increments idx.
  - After idx reaches expr_len-1, go to SEND_EQ.
- State SEND_EQ:
  - For exactly 1 cycle: ascii_out=0x3D, ready=1.
  - Then go to WAIT_RES with the timeout counter cleared.
  - Latency from load to '=' is expr_len+1 cycles; ready stays continuously high across all expr_len+1 characters.
- State WAIT_RES:
  - ready=0, ascii_out=0x00.
  - The counter increments each cycle.
  - If res_valid is high: capture result_out<=res_in, pulse done the next cycle, go to GAP.
  - Else if the counter reaches TIMEOUT-1: pulse timeout_err, leave result_out unchanged, go to GAP.
  - If res_valid is high on the same cycle the counter reaches TIMEOUT-1, the result wins: done pulses and timeout_err does not.
- State GAP:
  - Hold for GAP_CYC cycles with load_ready=0, then return to IDLE.
  - This gives the calculator time to clear its internal buffers.
- res_valid is ignored outside WAIT_RES: no capture and no pulse.
- load_valid is ignored outside IDLE; the host must hold it until load_ready.
- Reset mid-operation (any state): return to IDLE immediately with reset values; a partial stream is simply truncated.
- Width rules:
  - Token index is 4 bits and never wraps, because expr_len ≤ MAX_TOK ≤ 15.
  - The timeout counter is wide enough for TIMEOUT: 8 bits at the default.
  - result_out is copied from res_in unmodified; 0x7F is passed through as-is; interpreting it is the host's job.

Decomposition:
- Shared package aec_pkg, holding:
  - token code localparams (TOK_LPAREN=16 … TOK_SUB=20);
  - ASCII constants (ASC_EQ=0x3D, ASC_0, ASC_a, operator characters);
  - FSM state encoding (IDLE, SEND, SEND_EQ, WAIT_RES, GAP).
- One combinational sub-module, aec_tok2ascii: 5-bit token in, 8-bit ASCII plus tok_valid out.
  - It is used both for the load-time validity check (one instance per token, or a single loop) and for the SEND datapath.

Test Plan:
- Load "1+2*3", i.e. tokens {1,19,2,18,3}, len 5.
  - Response: ready high 6 consecutive cycles with ascii 0x31,0x2B,0x32,0x2A,0x33,0x3D.
  - Drive res_valid with res_in=7 three cycles later: done pulses and result_out=7.
  - load_ready returns after GAP_CYC=2 cycles.
- Load "(a-3)*2", i.e. {16,10,20,3,17,18,2}.
  - Response: stream 0x28,0x61,0x2D,0x33,0x29,0x2A,0x32,0x3D.
  - Closed loop with the calculator: result_out=14.
- Rejected loads:
  - Token value 25 at index 2 -> fmt_err pulses once, ready never rises, load_ready stays 1.
  - expr_len=0 -> fmt_err pulses.
  - expr_len=16 -> fmt_err pulses.
- Timeout and late result:
  - No res_valid after '=' -> timeout_err pulses exactly TIMEOUT=255 cycles after '=', result_out is unchanged, and done stays 0.
  - A res_valid arriving during GAP is ignored.
- Reset mid-stream: assert rst asynchronously during the 3rd character -> ready=0 and ascii_out=0x00 immediately, state IDLE, load_ready=1 after rst falls.
- Boundary cases:
  - A 15-token expression sends 16 characters, the last being 0x3D, with no index wrap.
  - res_valid on the last timeout cycle gives done=1 and timeout_err=0.
  - Back-to-back loads are separated by exactly GAP_CYC idle cycles.
